// File: rtl/planet_emp_pkg.sv
// Shared types and helpers for the Planet Empire game sequencer.
// Holds the game state enum, a counter width function and a saturating BCD increment.
package planet_emp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_t;

  // Bits needed to hold any value 0..n (at least 1).
  function automatic int f_width(input int unsigned n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/planet_emp_debounce.sv
// Switch conditioner: 2-FF synchronizer, tick-based debounce and press pulse.
// level is the debounced switch (1 = released); press pulses on its 1->0 edge.
module planet_emp_debounce
  import planet_emp_pkg::*;
#(
  parameter int unsigned DB_TICKS = 10_000
) (
  input  logic clk,
  input  logic rst,
  input  logic ee,
  input  logic sw_n,
  output logic level,
  output logic press
);

  localparam int CW = f_width(DB_TICKS);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= sw_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any agreement with the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (ee) begin
        if (cnt == CW'(DB_TICKS - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/planet_emp_game_ctrl.sv
// Planet Empire game sequencer: fire/clear pulses, empire pacing, hit scoring, round timer.
// Optional refire while the switch is held: define PLANET_EMP_AUTOFIRE_EN.
module planet_emp_game_ctrl
  import planet_emp_pkg::*;
#(
  parameter int unsigned C_DB_TICKS       = 10_000,
  parameter int unsigned C_GAME_TICKS     = 30_000_000,
  parameter int unsigned C_EMP_PER0       = 300_000,
  parameter int unsigned C_EMP_DEC        = 20_000,
  parameter int unsigned C_EMP_MIN        = 60_000,
  parameter int unsigned C_HIT_TICKS      = 500_000,
  parameter int unsigned C_AUTOFIRE_TICKS = 400_000
) (
  input  logic       CK_i,
  input  logic       RST_i,
  input  logic       EE_i,
  input  logic       XPSW_i,
  input  logic       MSL_BUSY_i,
  input  logic       MSL_TGT_i,
  input  logic       EMP_AT_TGT_i,
  output logic       FIRE_o,
  output logic       MSL_CLR_o,
  output logic       EMP_STEP_o,
  output logic       EMP_SEED_o,
  output logic       PLAY_o,
  output logic       HIT_o,
  output logic       OVER_o,
  output logic [7:0] SCORE_o
);

  localparam int GW = f_width(C_GAME_TICKS);
  localparam int PW = f_width(C_EMP_PER0);
  localparam int HW = f_width(C_HIT_TICKS);

  game_state_t   state, state_d;
  logic [GW-1:0] game_cnt, game_d;
  logic [PW-1:0] emp_cnt, emp_d;
  logic [PW-1:0] period, period_d;
  logic [1:0]    step_cnt, step_cnt_d;
  logic [HW-1:0] hit_cnt, hit_cnt_d;
  logic [7:0]    score, score_d;
  logic          fire_d, clr_d, step_d, seed_d;
  logic          hit_prev, hit_rise, expire;
  logic          psw, press;

  planet_emp_debounce #(.DB_TICKS(C_DB_TICKS)) u_fire_sw (
    .clk   (CK_i),
    .rst   (RST_i),
    .ee    (EE_i),
    .sw_n  (XPSW_i),
    .level (psw),
    .press (press)
  );

  assign hit_rise = MSL_TGT_i & EMP_AT_TGT_i & ~hit_prev;

`ifdef PLANET_EMP_AUTOFIRE_EN
  localparam int AW = f_width(C_AUTOFIRE_TICKS);
  logic [AW-1:0] af_cnt, af_d;

  always_ff @(posedge CK_i) begin
    if (RST_i) af_cnt <= '0;
    else       af_cnt <= af_d;
  end
`else
  localparam int unsigned UNUSED_AF_TICKS = C_AUTOFIRE_TICKS;
  logic unused_psw;
  assign unused_psw = psw;
`endif

  always_comb begin
    state_d    = state;
    game_d     = game_cnt;
    emp_d      = emp_cnt;
    period_d   = period;
    step_cnt_d = step_cnt;
    hit_cnt_d  = hit_cnt;
    score_d    = score;
    fire_d     = 1'b0;
    clr_d      = 1'b0;
    step_d     = 1'b0;
    seed_d     = 1'b0;
    expire     = 1'b0;
`ifdef PLANET_EMP_AUTOFIRE_EN
    af_d       = '0;
`endif
    case (state)
      ST_IDLE, ST_OVER: begin
        if (press) begin
          state_d    = ST_PLAY;
          clr_d      = 1'b1;
          score_d    = 8'h00;
          period_d   = PW'(C_EMP_PER0);
          game_d     = GW'(C_GAME_TICKS);
          emp_d      = '0;
          step_cnt_d = '0;
          hit_cnt_d  = '0;
        end
      end
      default: begin
        if (EE_i) begin
          if (game_cnt <= GW'(1)) begin
            game_d = '0;
            expire = 1'b1;
          end else begin
            game_d = game_cnt - 1'b1;
          end
        end
        if (state == ST_PLAY) begin
          // >= covers a counter left above a freshly shortened period.
          if (EE_i) begin
            if (emp_cnt >= period - 1'b1) begin
              emp_d      = '0;
              step_d     = 1'b1;
              seed_d     = (step_cnt == 2'd3);
              step_cnt_d = step_cnt + 1'b1;
            end else begin
              emp_d = emp_cnt + 1'b1;
            end
          end
          if (expire) begin
            state_d = ST_OVER;
            clr_d   = 1'b1;
          end else if (hit_rise) begin
            state_d   = ST_HIT;
            clr_d     = 1'b1;
            score_d   = bcd_inc_sat(score);
            hit_cnt_d = '0;
            if (32'(period) >= C_EMP_MIN + C_EMP_DEC)
              period_d = period - PW'(C_EMP_DEC);
            else
              period_d = PW'(C_EMP_MIN);
          end else begin
            if (press && !MSL_BUSY_i) fire_d = 1'b1;
`ifdef PLANET_EMP_AUTOFIRE_EN
            af_d = af_cnt;
            if (press || psw) begin
              af_d = '0;
            end else if (EE_i) begin
              if (af_cnt == AW'(C_AUTOFIRE_TICKS - 1)) begin
                af_d = '0;
                if (!MSL_BUSY_i) fire_d = 1'b1;
              end else begin
                af_d = af_cnt + 1'b1;
              end
            end
`endif
          end
        end else begin
          if (expire) begin
            state_d = ST_OVER;
            clr_d   = 1'b1;
          end else if (EE_i) begin
            if (hit_cnt == HW'(C_HIT_TICKS - 1)) begin
              state_d   = ST_PLAY;
              hit_cnt_d = '0;
            end else begin
              hit_cnt_d = hit_cnt + 1'b1;
            end
          end
        end
        // Nothing leaves the block once the round has ended.
        if (expire) begin
          step_d = 1'b0;
          seed_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state      <= ST_IDLE;
      game_cnt   <= '0;
      emp_cnt    <= '0;
      period     <= PW'(C_EMP_PER0);
      step_cnt   <= '0;
      hit_cnt    <= '0;
      score      <= 8'h00;
      hit_prev   <= 1'b0;
      FIRE_o     <= 1'b0;
      MSL_CLR_o  <= 1'b0;
      EMP_STEP_o <= 1'b0;
      EMP_SEED_o <= 1'b0;
    end else begin
      state      <= state_d;
      game_cnt   <= game_d;
      emp_cnt    <= emp_d;
      period     <= period_d;
      step_cnt   <= step_cnt_d;
      hit_cnt    <= hit_cnt_d;
      score      <= score_d;
      hit_prev   <= MSL_TGT_i & EMP_AT_TGT_i;
      FIRE_o     <= fire_d;
      MSL_CLR_o  <= clr_d;
      EMP_STEP_o <= step_d;
      EMP_SEED_o <= seed_d;
    end
  end

  assign PLAY_o  = (state == ST_PLAY) || (state == ST_HIT);
  assign HIT_o   = (state == ST_HIT);
  assign OVER_o  = (state == ST_OVER);
  assign SCORE_o = score;

endmodule

// File: tb/tb_planet_emp_game_ctrl.sv
// Bench for planet_emp_game_ctrl: small-parameter instances driven with randomized
// stimulus and checked against tick-counting expectations held in the bench.
module tb_planet_emp_game_ctrl;

  localparam int unsigned DB   = 4;
  localparam int unsigned PER0 = 8;
  localparam int unsigned DEC  = 2;
  localparam int unsigned MINP = 4;
  localparam int unsigned HITT = 10;

  logic clk, rst, ee, xpsw, busy, tgt, emp_at;
  logic fire, clr, step, seed, play, hit, over;
  logic fire_e, clr_e, step_e, seed_e, play_e, hit_e, over_e;
  logic [7:0] score, score_e;

  int checks = 0;
  int errors = 0;

  planet_emp_game_ctrl #(
    .C_DB_TICKS(DB), .C_GAME_TICKS(20000), .C_EMP_PER0(PER0), .C_EMP_DEC(DEC),
    .C_EMP_MIN(MINP), .C_HIT_TICKS(HITT)
  ) u_dut (
    .CK_i(clk), .RST_i(rst), .EE_i(ee), .XPSW_i(xpsw), .MSL_BUSY_i(busy),
    .MSL_TGT_i(tgt), .EMP_AT_TGT_i(emp_at), .FIRE_o(fire), .MSL_CLR_o(clr),
    .EMP_STEP_o(step), .EMP_SEED_o(seed), .PLAY_o(play), .HIT_o(hit),
    .OVER_o(over), .SCORE_o(score)
  );

  planet_emp_game_ctrl #(
    .C_DB_TICKS(DB), .C_GAME_TICKS(50), .C_EMP_PER0(PER0), .C_EMP_DEC(DEC),
    .C_EMP_MIN(MINP), .C_HIT_TICKS(HITT)
  ) u_end (
    .CK_i(clk), .RST_i(rst), .EE_i(ee), .XPSW_i(xpsw), .MSL_BUSY_i(busy),
    .MSL_TGT_i(tgt), .EMP_AT_TGT_i(emp_at), .FIRE_o(fire_e), .MSL_CLR_o(clr_e),
    .EMP_STEP_o(step_e), .EMP_SEED_o(seed_e), .PLAY_o(play_e), .HIT_o(hit_e),
    .OVER_o(over_e), .SCORE_o(score_e)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic test_reset();
    rst = 1'b1; ee = 1'b1; xpsw = 1'b1; busy = 1'b0; tgt = 1'b0; emp_at = 1'b0;
    repeat (3) tick();
    checks++;
    if ({fire, clr, step, seed, play, hit, over} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000000", {fire, clr, step, seed, play, hit, over});
    end
    checks++;
    if (score !== 8'h00) begin
      errors++; $display("FAIL reset_score: got %h expected 00", score);
    end
    checks++;
    if ({fire_e, clr_e, step_e, play_e, over_e, score_e} !== 13'b0) begin
      errors++; $display("FAIL reset_end_inst: got %b expected 0", {fire_e, clr_e, step_e, play_e, over_e, score_e});
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (play !== 1'b0 || over !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: play=%b over=%b expected 0 0", play, over);
    end
  endtask

  task automatic test_debounce();
    int g, nclr, nfire;
    g = $urandom_range(1, DB - 1);
    nclr = 0; nfire = 0;
    xpsw = 1'b0;
    repeat (g) begin tick(); nclr += int'(clr); end
    xpsw = 1'b1;
    repeat (12) begin tick(); nclr += int'(clr); end
    checks++;
    if (nclr != 0 || play !== 1'b0) begin
      errors++; $display("FAIL glitch_%0d: clr=%0d play=%b expected 0 0", g, nclr, play);
    end
    xpsw = 1'b0;
    repeat (DB) begin tick(); nclr += int'(clr); nfire += int'(fire); end
    xpsw = 1'b1;
    repeat (12) begin tick(); nclr += int'(clr); nfire += int'(fire); end
    checks++;
    if (nclr != 1 || play !== 1'b1) begin
      errors++; $display("FAIL press_start: clr=%0d play=%b expected 1 1", nclr, play);
    end
    checks++;
    if (nfire != 0) begin
      errors++; $display("FAIL press_from_idle_fire: got %0d expected 0", nfire);
    end
  endtask

  task automatic test_pacing();
    int ticks, nsteps;
    bit found, exp_step, exp_seed;
    rst = 1'b1; ee = 1'b1; tick(); rst = 1'b0;
    xpsw = 1'b0; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (play) found = 1;
    end
    checks++;
    if (!found || clr !== 1'b1) begin
      errors++; $display("FAIL pacing_start: found=%0d clr=%b expected 1 1", found, clr);
    end
    xpsw = 1'b1; ticks = 0; nsteps = 0;
    for (int i = 0; i < 240; i++) begin
      ee = 1'($urandom_range(0, 1));
      tick();
      if (ee) ticks++;
      exp_step = ee && (ticks % PER0 == 0);
      exp_seed = exp_step && ((ticks / PER0) % 4 == 0);
      if (exp_step) nsteps++;
      checks++;
      if (step !== exp_step || seed !== exp_seed) begin
        errors++;
        $display("FAIL pacing_tick_%0d: step=%b seed=%b expected %b %b", ticks, step, seed, exp_step, exp_seed);
      end
    end
    checks++;
    if (nsteps < 12) begin
      errors++; $display("FAIL pacing_coverage: steps=%0d expected at least 12", nsteps);
    end
    ee = 1'b1;
  endtask

  task automatic test_fire();
    int nf, b;
    for (int t = 0; t < 5; t++) begin
      b = (t == 0) ? 0 : (t == 1) ? 1 : int'($urandom_range(0, 1));
      busy = 1'(b); nf = 0;
      xpsw = 1'b0;
      repeat (DB + 2) begin tick(); nf += int'(fire); end
      xpsw = 1'b1;
      repeat (DB + 4) begin tick(); nf += int'(fire); end
      busy = 1'b0;
      repeat (8) begin tick(); nf += int'(fire); end
      checks++;
      if (nf != (b ? 0 : 1)) begin
        errors++; $display("FAIL fire_busy_%0d: fires=%0d expected %0d", b, nf, b ? 0 : 1);
      end
    end
  endtask

  task automatic test_hit_score();
    int n, per, hold, hit_len, nclr, gap;
    bit found, got;
    n = 0; per = PER0;
    for (int k = 1; k <= 12; k++) begin
      hold = $urandom_range(1, 3);
      tgt = 1'b1; emp_at = 1'b1;
      tick();
      n = (n < 99) ? n + 1 : 99;
      per = (per - int'(DEC) > int'(MINP)) ? per - int'(DEC) : int'(MINP);
      checks++;
      if (hit !== 1'b1 || score !== to_bcd(n)) begin
        errors++; $display("FAIL hit_%0d: hit=%b score=%h expected 1 %h", k, hit, score, to_bcd(n));
      end
      hit_len = int'(hit); nclr = int'(clr);
      for (int i = 1; i < 30; i++) begin
        if (i >= hold) begin tgt = 1'b0; emp_at = 1'b0; end
        tick();
        hit_len += int'(hit); nclr += int'(clr);
      end
      checks++;
      if (hit_len != HITT || nclr != 1) begin
        errors++; $display("FAIL hit_flash_%0d: hit_cycles=%0d clr=%0d expected %0d 1", k, hit_len, nclr, HITT);
      end
      found = 0; got = 0; gap = 0;
      for (int i = 0; i < 30 && !found; i++) begin tick(); if (step) found = 1; end
      for (int i = 0; i < 30 && !got; i++) begin tick(); gap++; if (step) got = 1; end
      checks++;
      if (!found || !got || gap != per) begin
        errors++; $display("FAIL period_after_hit_%0d: gap=%0d expected %0d", k, gap, per);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (play !== 1'b0 || clr !== 1'b0 || score !== 8'h00) begin
      errors++; $display("FAIL mid_reset: play=%b clr=%b score=%h expected 0 0 00", play, clr, score);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_end();
    bit found;
    int npulse;
    rst = 1'b1; ee = 1'b1; repeat (2) tick(); rst = 1'b0;
    xpsw = 1'b0; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin tick(); if (play_e) found = 1; end
    checks++;
    if (!found) begin
      errors++; $display("FAIL end_start: play=%b expected 1", play_e);
    end
    xpsw = 1'b1;
    repeat (48) tick();
    tgt = 1'b1; emp_at = 1'b1;
    tick();
    checks++;
    if (hit_e !== 1'b1 || over_e !== 1'b0 || score_e !== 8'h01) begin
      errors++; $display("FAIL end_hit_49: hit=%b over=%b score=%h expected 1 0 01", hit_e, over_e, score_e);
    end
    tgt = 1'b0; emp_at = 1'b0;
    tick();
    checks++;
    if (over_e !== 1'b1 || hit_e !== 1'b0 || play_e !== 1'b0 || clr_e !== 1'b1) begin
      errors++; $display("FAIL end_over_50: over=%b hit=%b play=%b clr=%b expected 1 0 0 1", over_e, hit_e, play_e, clr_e);
    end
    npulse = 0;
    repeat (6) begin tick(); npulse += int'(clr_e) + int'(fire_e) + int'(step_e); end
    checks++;
    if (npulse != 0 || score_e !== 8'h01 || over_e !== 1'b1) begin
      errors++; $display("FAIL end_hold: pulses=%0d score=%h over=%b expected 0 01 1", npulse, score_e, over_e);
    end
    xpsw = 1'b0; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin tick(); if (play_e) found = 1; end
    checks++;
    if (!found || clr_e !== 1'b1 || score_e !== 8'h00) begin
      errors++; $display("FAIL end_restart: play=%b clr=%b score=%h expected 1 1 00", play_e, clr_e, score_e);
    end
    xpsw = 1'b1;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_pacing();
    test_fire();
    test_hit_score();
    test_mid_reset();
    test_round_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/planet_emp_game_ctrl.md
Name: planet_emp_game_ctrl

Overview:
Game sequencer for the Planet Empire core. It debounces the fire push-switch and issues missile launch and clear pulses. It paces the empire shift register with a period that shortens as the player scores, detects hits, keeps a 2-digit BCD score and runs the round timer through IDLE/PLAY/HIT/OVER. All timing is in EE_i ticks, the 1 us prescaler enable supplied by the core.

Parameters:
C_DB_TICKS, 10_000, debounce stability window in EE ticks
C_GAME_TICKS, 30_000_000, round length in EE ticks
C_EMP_PER0, 300_000, initial empire step period in EE ticks
C_EMP_DEC, 20_000, period reduction per hit
C_EMP_MIN, 60_000, period floor
C_HIT_TICKS, 500_000, hit-flash duration in EE ticks
C_AUTOFIRE_TICKS, 400_000, refire interval (optional feature only)

Ports:
CK_i  in  1  system clock
RST_i  in  1  synchronous reset, active-high
EE_i  in  1  1-cycle tick enable, 1 us
XPSW_i  in  1  raw fire switch, active-low, asynchronous
MSL_BUSY_i  in  1  missile in flight (decade counter not parked)
MSL_TGT_i  in  1  missile at target row (level)
EMP_AT_TGT_i  in  1  empire bit present at target column
FIRE_o  out  1  1-cycle launch pulse
MSL_CLR_o  out  1  1-cycle missile clear pulse
EMP_STEP_o  out  1  1-cycle empire shift pulse
EMP_SEED_o  out  1  shift-in data, valid with EMP_STEP_o
PLAY_o  out  1  high in PLAY and HIT
HIT_o  out  1  high in HIT
OVER_o  out  1  high in OVER
SCORE_o  out  8  BCD {tens,ones}, 00..99

Behaviour:
- Reset: state IDLE. All pulse outputs are 0. PLAY_o, HIT_o and OVER_o are 0. SCORE_o=8'h00. Empire period = C_EMP_PER0. All counters are 0.
- Input sync: XPSW_i passes through a 2-FF synchronizer, then debounce. The debounced value PSW updates only after the synced input has differed from PSW for C_DB_TICKS consecutive EE ticks. A mismatch that clears before the count completes restarts the count. PRESS = one-cycle pulse on the PSW 1->0 edge.
- IDLE: on PRESS -> PLAY. Entering PLAY clears the score, sets period = C_EMP_PER0, loads the game timer and emits one MSL_CLR_o.
- PLAY:
  - Game timer decrements each EE. When it reaches 0 the FSM goes to OVER (MSL_CLR_o is pulsed).
  - Empire counter increments each EE. When it reaches period-1 it wraps to 0, emits EMP_STEP_o and sets EMP_SEED_o = 1 every 4th step (2-bit step counter == 3), 0 otherwise.
  - FIRE_o is emitted on PRESS only when MSL_BUSY_i=0. A PRESS while the missile is busy is dropped, not queued.
  - Hit = MSL_TGT_i & EMP_AT_TGT_i, sampled on its rising edge (registered previous value). On a hit: -> HIT, MSL_CLR_o, score +1 in BCD (09->10; saturates at 99), period = max(period-C_EMP_DEC, C_EMP_MIN).
- HIT: the game timer keeps running. The empire counter is frozen and PRESS is ignored. After C_HIT_TICKS EE ticks -> PLAY. If the timer expires during HIT -> OVER (timer has priority).
- OVER: score is held and no pulses are generated. PRESS -> PLAY, with the same entry actions as from IDLE.
- Simultaneous events in one cycle: timer expiry beats hit, and hit beats fire. If a hit and a step coincide, the step is still emitted.
- FIRE_o, MSL_CLR_o and EMP_STEP_o are registered: they assert the cycle after the qualifying condition, never for more than 1 cycle.
- Counter widths come from log2 of each parameter.
- RST_i mid-game returns to IDLE immediately, without an MSL_CLR_o.

Optional Feature:
PLANET_EMP_AUTOFIRE_EN
- Defined: in PLAY, while PSW=0 a refire counter runs on EE. Every C_AUTOFIRE_TICKS it emits a FIRE_o if MSL_BUSY_i=0. The counter resets on PRESS and on release.
- Undefined: one FIRE_o per press only. No refire logic is present.

Decomposition:
- Package planet_emp_pkg: state enum (IDLE, PLAY, HIT, OVER), the log2 constant function, and a BCD increment-with-saturate function.
- One sub-module, planet_emp_debounce: synchronizer, debounce counter and PRESS edge output. It is reused for future switches.

Test Plan:
- Reset behaviour: RST_i held 3 cycles, XPSW_i=1 -> state IDLE; SCORE_o=00; all outputs 0.
- Debounce: small parameters (DB=4, all EE=1). A 3-tick low glitch -> no PRESS; a 4-tick low -> exactly one PRESS, and IDLE->PLAY with one MSL_CLR_o.
- Empire pacing: PER0=8, no hits -> EMP_STEP_o every 8 EE ticks. EMP_SEED_o=1 on steps 4, 8, 12.
- Fire gating: PRESS with MSL_BUSY_i=0 -> one FIRE_o. PRESS with MSL_BUSY_i=1 -> none, and no later FIRE_o after busy drops.
- Hit and score: 12 hits with DEC=2, MIN=4 -> SCORE_o goes 01..09,10,11,12. Period steps 8->6->4 and then stays at 4. Each hit gives one MSL_CLR_o and HIT_o for C_HIT_TICKS.
- Round end: GAME=50 with a hit timed to land at tick 49 -> OVER at tick 50 from HIT; score held. A PRESS in OVER -> PLAY with SCORE_o=00.
